// File: rtl/tank_turn_sequencer_if.sv
// Storage-block bus for the tank game: mode-selected register file.
// Read data returns one cycle after the mode is presented.
interface tank_turn_sequencer_if;
   logic [3:0] st_mode;
   logic       st_wren;
   logic [7:0] st_address;
   logic [7:0] st_data;
   logic [7:0] st_q;

   modport master (output st_mode, st_wren, st_address, st_data, input st_q);
   modport slave  (input st_mode, st_wren, st_address, st_data, output st_q);
endinterface

// File: rtl/tank_turn_sequencer.sv
// Per-tick turn controller: reads eight storage registers, resolves moves,
// projectile flight, hits and firing, then writes all eight back in order.
module tank_turn_sequencer #(
   parameter int GRID_BITS = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         tick,
   input  logic                         p1_move,
   input  logic [1:0]                   p1_dir,
   input  logic                         p1_fire,
   input  logic                         p2_move,
   input  logic [1:0]                   p2_dir,
   input  logic                         p2_fire,
   tank_turn_sequencer_if.master        st,
   output logic                         busy,
   output logic                         done,
   output logic [1:0]                   hit
);
   localparam int PW = 2 * GRID_BITS;
   typedef logic [GRID_BITS-1:0] coord_t;
   typedef enum logic [2:0] {IDLE, READ, CALC, WRITE, DONE} state_t;

   // Register slots are mode-1: t1 pos/dir, t2 pos/dir, pr1 addr/dir, pr2 addr/dir.
   function automatic logic [3:0] mode_of(input logic [2:0] i);
      case (i)
         3'd0:    return 4'b0001;
         3'd1:    return 4'b0010;
         3'd2:    return 4'b0101;
         3'd3:    return 4'b0110;
         3'd4:    return 4'b0011;
         3'd5:    return 4'b0100;
         3'd6:    return 4'b0111;
         default: return 4'b1000;
      endcase
   endfunction

   function automatic logic [2:0] slot_of(input logic [2:0] i);
      return 3'(mode_of(i) - 4'd1);
   endfunction

   // Returns {ok, stepped position}; ok=0 when the step would cross an edge.
   function automatic logic [8:0] step_cell(input logic [7:0] pos, input logic [1:0] dir);
      coord_t     x, y;
      logic       ok;
      logic [7:0] np;
      x  = pos[GRID_BITS-1:0];
      y  = pos[PW-1:GRID_BITS];
      ok = 1'b1;
      np = pos;
      case (dir)
         2'd0:    if (y == '0) ok = 1'b0; else y = y - coord_t'(1);
         2'd1:    if (x == '1) ok = 1'b0; else x = x + coord_t'(1);
         2'd2:    if (y == '1) ok = 1'b0; else y = y + coord_t'(1);
         default: if (x == '0) ok = 1'b0; else x = x - coord_t'(1);
      endcase
      np[PW-1:0] = {y, x};
      return {ok, np};
   endfunction

   state_t          state_q, state_d;
   logic [2:0]      idx_q, idx_d;
   logic [6:0][7:0] rd_q, rd_d;
   logic [7:0][7:0] res_q, res_d, res_c;
   logic [1:0]      hit_q, hit_d, hit_c;
   logic            p1_mv_q, p1_mv_d, p1_fr_q, p1_fr_d;
   logic            p2_mv_q, p2_mv_d, p2_fr_q, p2_fr_d;
   logic [1:0]      p1_dir_q, p1_dir_d, p2_dir_q, p2_dir_d;

   // Turn arithmetic; the last read (pr2 dir) is taken straight from st_q.
   logic [7:0] t1p, t2p, a1, a2;
   logic [1:0] t1d, t2d, d1, d2;
   logic       act1, act2;
   logic [8:0] s;
   always_comb begin
      t1p   = rd_q[0];
      t1d   = rd_q[1][1:0];
      t2p   = rd_q[2];
      t2d   = rd_q[3][1:0];
      a1    = rd_q[4];
      act1  = rd_q[5][7];
      d1    = rd_q[5][1:0];
      a2    = rd_q[6];
      act2  = st.st_q[7];
      d2    = st.st_q[1:0];
      s     = '0;
      hit_c = '0;
      if (p1_mv_q) begin
         t1d = p1_dir_q;
         s   = step_cell(t1p, p1_dir_q);
         if (s[8] && s[7:0] != t2p) t1p = s[7:0];
      end
      if (p2_mv_q) begin
         t2d = p2_dir_q;
         s   = step_cell(t2p, p2_dir_q);
         if (s[8] && s[7:0] != t1p) t2p = s[7:0];
      end
      if (act1) begin
         s = step_cell(a1, d1);
         if (!s[8]) act1 = 1'b0;
         else if (s[7:0] == t2p) begin
            act1     = 1'b0;
            hit_c[1] = 1'b1;
         end else a1 = s[7:0];
      end
      if (act2) begin
         s = step_cell(a2, d2);
         if (!s[8]) act2 = 1'b0;
         else if (s[7:0] == t1p) begin
            act2     = 1'b0;
            hit_c[0] = 1'b1;
         end else a2 = s[7:0];
      end
      if (p1_fr_q && !act1) begin
         a1   = t1p;
         act1 = 1'b1;
         d1   = t1d;
      end
      if (p2_fr_q && !act2) begin
         a2   = t2p;
         act2 = 1'b1;
         d2   = t2d;
      end
      res_c[0] = t1p;
      res_c[1] = {6'b0, t1d};
      res_c[2] = t2p;
      res_c[3] = {6'b0, t2d};
      res_c[4] = a1;
      res_c[5] = {act1, 5'b0, d1};
      res_c[6] = a2;
      res_c[7] = {act2, 5'b0, d2};
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      rd_d     = rd_q;
      res_d    = res_q;
      hit_d    = hit_q;
      p1_mv_d  = p1_mv_q;
      p1_fr_d  = p1_fr_q;
      p2_mv_d  = p2_mv_q;
      p2_fr_d  = p2_fr_q;
      p1_dir_d = p1_move ? p1_dir : p1_dir_q;
      p2_dir_d = p2_move ? p2_dir : p2_dir_q;
      case (state_q)
         IDLE: if (tick) begin
            state_d = READ;
            idx_d   = '0;
         end
         READ: begin
            if (idx_q != 3'd0) rd_d[slot_of(idx_q - 3'd1)] = st.st_q;
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) state_d = CALC;
         end
         CALC: begin
            res_d   = res_c;
            hit_d   = hit_c;
            p1_mv_d = 1'b0;
            p1_fr_d = 1'b0;
            p2_mv_d = 1'b0;
            p2_fr_d = 1'b0;
            idx_d   = '0;
            state_d = WRITE;
         end
         WRITE: begin
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
      // Pulses always land after the CALC clear so they carry to the next turn.
      p1_mv_d = p1_mv_d | p1_move;
      p1_fr_d = p1_fr_d | p1_fire;
      p2_mv_d = p2_mv_d | p2_move;
      p2_fr_d = p2_fr_d | p2_fire;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         rd_q     <= '0;
         res_q    <= '0;
         hit_q    <= '0;
         p1_mv_q  <= 1'b0;
         p1_fr_q  <= 1'b0;
         p2_mv_q  <= 1'b0;
         p2_fr_q  <= 1'b0;
         p1_dir_q <= '0;
         p2_dir_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         rd_q     <= rd_d;
         res_q    <= res_d;
         hit_q    <= hit_d;
         p1_mv_q  <= p1_mv_d;
         p1_fr_q  <= p1_fr_d;
         p2_mv_q  <= p2_mv_d;
         p2_fr_q  <= p2_fr_d;
         p1_dir_q <= p1_dir_d;
         p2_dir_q <= p2_dir_d;
      end
   end

   // Outputs decode from state so an async reset drops them at once.
   always_comb begin
      st.st_mode    = '0;
      st.st_wren    = 1'b0;
      st.st_address = '0;
      st.st_data    = '0;
      if (state_q == READ) st.st_mode = mode_of(idx_q);
      if (state_q == WRITE) begin
         st.st_mode = mode_of(idx_q);
         st.st_wren = 1'b1;
         st.st_data = res_q[slot_of(idx_q)];
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign hit  = (state_q == DONE) ? hit_q : 2'b00;

   logic unused_bits;
   assign unused_bits = ^{rd_q[1][7:2], rd_q[3][7:2], rd_q[5][6:2], st.st_q[6:2]};
endmodule

// File: tb/tb_tank_turn_sequencer.sv
// Directed bench: storage model, table of single-turn vectors, then
// hand-written sequences for busy-tick, late requests and mid-turn reset.
module tb_tank_turn_sequencer;
   logic       clk = 1'b0, reset = 1'b0, tick = 1'b0;
   logic       p1_move = 1'b0, p1_fire = 1'b0, p2_move = 1'b0, p2_fire = 1'b0;
   logic [1:0] p1_dir = 2'd0, p2_dir = 2'd0;
   logic       busy, done;
   logic [1:0] hit;

   tank_turn_sequencer_if st_if();

   tank_turn_sequencer #(.GRID_BITS(4)) dut (
      .clk(clk), .reset(reset), .tick(tick),
      .p1_move(p1_move), .p1_dir(p1_dir), .p1_fire(p1_fire),
      .p2_move(p2_move), .p2_dir(p2_dir), .p2_fire(p2_fire),
      .st(st_if.master), .busy(busy), .done(done), .hit(hit)
   );

   always #5 clk = ~clk;

   // Storage model: registered read, write on wren, bench-side preload.
   logic [7:0]      mem [16];
   logic [7:0][7:0] load_buf;
   logic            load_req = 1'b0;
   always @(posedge clk) begin
      if (load_req) begin
         for (int i = 0; i < 8; i++) mem[i+1] <= load_buf[i];
      end else if (st_if.st_wren) mem[st_if.st_mode] <= st_if.st_data;
      st_if.st_q <= mem[st_if.st_mode];
   end

   int checks = 0, errors = 0;
   logic [3:0] ord [8] = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd4, 4'd7, 4'd8};

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   function automatic logic [7:0][7:0] regs(input logic [7:0] t1p, t1d, t2p, t2d,
                                            a1, d1, a2, d2);
      logic [7:0][7:0] r;
      r[0] = t1p; r[1] = t1d; r[2] = t2p; r[3] = t2d;
      r[4] = a1;  r[5] = d1;  r[6] = a2;  r[7] = d2;
      return r;
   endfunction

   task automatic preload(input logic [7:0][7:0] v);
      @(negedge clk);
      load_buf = v;
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   task automatic pulse_req(input logic m1, input logic [1:0] d1, input logic f1,
                            input logic m2, input logic [1:0] d2, input logic f2);
      @(negedge clk);
      p1_move = m1; p1_dir = d1; p1_fire = f1;
      p2_move = m2; p2_dir = d2; p2_fire = f2;
      @(negedge clk);
      p1_move = 1'b0; p1_fire = 1'b0; p2_move = 1'b0; p2_fire = 1'b0;
   endtask

   task automatic check_mem(input string n, input logic [7:0][7:0] e);
      for (int i = 0; i < 8; i++) chk($sformatf("%s reg%0d", n, i + 1), 32'(mem[i+1]), 32'(e[i]));
   endtask

   // Cycle c counts edges after the one that samples tick; checks on negedges.
   task automatic run_turn(input string n, input logic [1:0] exp_hit, input int tick_at,
                           input int mv_at, input int rst_at);
      int bad = 0, nd = 0;
      logic [1:0] hs = 2'b00;
      logic aborted = 1'b0;
      logic busy_e, wren_e, done_e;
      logic [3:0] mode_e;
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      for (int c = 1; c <= 22; c++) begin
         if (c == tick_at) tick = 1'b1;
         if (c == mv_at) begin p1_move = 1'b1; p1_dir = 2'd1; end
         if (aborted && c == rst_at + 1) reset = 1'b1;
         if (c == rst_at) begin
            reset = 1'b0;
            #1;
            chk({n, " abort"}, {busy, st_if.st_wren, st_if.st_mode, done}, 0);
            aborted = 1'b1;
         end
         if (!aborted) begin
            busy_e = (c <= 18);
            wren_e = (c >= 10 && c <= 17);
            done_e = (c == 18);
            mode_e = (c <= 8) ? ord[c-1] : (wren_e ? ord[c-10] : 4'd0);
            if ({busy, st_if.st_wren, st_if.st_mode, done} !== {busy_e, wren_e, mode_e, done_e}
                || st_if.st_address !== 8'h00) bad++;
            if (done) begin nd++; hs = hit; end
            else if (hit !== 2'b00) bad++;
         end
         @(negedge clk);
         tick = 1'b0;
         p1_move = 1'b0;
      end
      if (rst_at == 0) begin
         chk({n, " timing"}, bad, 0);
         chk({n, " done count"}, nd, 1);
         chk({n, " hit"}, 32'(hs), 32'(exp_hit));
      end
   endtask

   typedef struct {
      string           name;
      logic [7:0][7:0] init;
      logic            m1;
      logic [1:0]      d1;
      logic            f1;
      logic            m2;
      logic [1:0]      d2;
      logic            f2;
      logic [7:0][7:0] exp;
      logic [1:0]      hit;
   } vec_t;

   vec_t v [11];

   initial begin
      v[0]  = '{"basic",      regs(8'h55,0,8'hAA,0,0,0,0,0), 1,2'd1,0, 0,2'd0,0,
                regs(8'h56,1,8'hAA,0,0,0,0,0), 2'b00};
      v[1]  = '{"edge_up",    regs(8'h00,2,8'hAA,0,0,0,0,0), 1,2'd0,0, 0,2'd0,0,
                regs(8'h00,0,8'hAA,0,0,0,0,0), 2'b00};
      v[2]  = '{"block_t2",   regs(8'h33,0,8'h34,0,0,0,0,0), 1,2'd1,0, 0,2'd0,0,
                regs(8'h33,1,8'h34,0,0,0,0,0), 2'b00};
      v[3]  = '{"block_new",  regs(8'h33,0,8'h35,0,0,0,0,0), 1,2'd1,0, 1,2'd3,0,
                regs(8'h34,1,8'h35,3,0,0,0,0), 2'b00};
      v[4]  = '{"fire",       regs(0,0,8'h80,1,0,0,0,0), 0,2'd0,0, 0,2'd0,1,
                regs(0,0,8'h80,1,0,0,8'h80,8'h81), 2'b00};
      v[5]  = '{"flight",     regs(0,0,8'h80,1,0,0,8'h80,8'h81), 0,2'd0,0, 0,2'd0,0,
                regs(0,0,8'h80,1,0,0,8'h81,8'h81), 2'b00};
      v[6]  = '{"exit_edge",  regs(0,0,8'h80,1,0,0,8'h8F,8'h81), 0,2'd0,0, 0,2'd0,0,
                regs(0,0,8'h80,1,0,0,8'h8F,8'h01), 2'b00};
      v[7]  = '{"fire_act",   regs(0,0,8'h80,1,0,0,8'h81,8'h81), 0,2'd0,0, 0,2'd0,1,
                regs(0,0,8'h80,1,0,0,8'h82,8'h81), 2'b00};
      v[8]  = '{"hit_t2",     regs(0,0,8'h44,0,8'h43,8'h81,0,0), 0,2'd0,0, 0,2'd0,0,
                regs(0,0,8'h44,0,8'h43,8'h01,0,0), 2'b10};
      v[9]  = '{"hit_t1",     regs(8'h11,0,8'hAA,0,0,0,8'h21,8'h80), 0,2'd0,0, 0,2'd0,0,
                regs(8'h11,0,8'hAA,0,0,0,8'h21,8'h00), 2'b01};
      v[10] = '{"multi",      regs(8'h12,0,8'h40,0,0,0,0,0), 1,2'd2,1, 1,2'd3,0,
                regs(8'h22,2,8'h40,3,8'h22,8'h82,0,0), 2'b00};

      repeat (3) @(negedge clk);
      chk("reset outputs", {busy, done, hit, st_if.st_wren, st_if.st_mode,
                            st_if.st_address, st_if.st_data}, 0);
      reset = 1'b1;

      for (int i = 0; i < 11; i++) begin
         preload(v[i].init);
         pulse_req(v[i].m1, v[i].d1, v[i].f1, v[i].m2, v[i].d2, v[i].f2);
         run_turn(v[i].name, v[i].hit, 0, 0, 0);
         check_mem(v[i].name, v[i].exp);
      end

      // tick while busy, mid-turn and on the done cycle
      preload(regs(8'h55,0,8'hAA,0,0,0,0,0));
      run_turn("tick_busy_mid", 2'b00, 5, 0, 0);
      run_turn("tick_busy_done", 2'b00, 18, 0, 0);
      check_mem("tick_busy", regs(8'h55,0,8'hAA,0,0,0,0,0));

      // move arriving after CALC waits for the next turn
      run_turn("late_move", 2'b00, 0, 12, 0);
      check_mem("late_move", regs(8'h55,0,8'hAA,0,0,0,0,0));
      run_turn("late_move_next", 2'b00, 0, 0, 0);
      check_mem("late_move_next", regs(8'h56,1,8'hAA,0,0,0,0,0));

      // reset mid-write, then a clean turn from IDLE
      preload(regs(8'h55,0,8'hAA,0,0,0,0,0));
      pulse_req(1, 2'd1, 0, 0, 2'd0, 0);
      run_turn("reset_mid", 2'b00, 0, 0, 12);
      chk("idle after reset", {busy, done}, 0);
      preload(regs(8'h55,0,8'hAA,0,0,0,0,0));
      pulse_req(1, 2'd1, 0, 0, 2'd0, 0);
      run_turn("after_reset", 2'b00, 0, 0, 0);
      check_mem("after_reset", regs(8'h56,1,8'hAA,0,0,0,0,0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
